mem_wb_stage: RTL and testbench

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

---
 rtl/riscv_pkg.sv | 41 ++++
 rtl/load_extend.sv | 46 ++++
 rtl/mem_wb_stage.sv | 100 ++++++++++
 tb/tb_mem_wb_stage.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline encodings: write-back select codes, load funct3
// values and the write-back bundle type used by the MEM/WB register.
package riscv_pkg;

    // Write-back data source select (InWbSel)
    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_LOAD = 2'b01;
    localparam logic [1:0] WB_PC4  = 2'b10;
    localparam logic [1:0] WB_RSVD = 2'b11;

    // Load funct3 encodings
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // One registered write-back slot
    typedef struct packed {
        logic        reg_write;
        logic [4:0]  write_addr;
        logic [31:0] write_data;
        logic        load_fault;
    } wb_bundle_t;

    localparam wb_bundle_t WB_BUBBLE = '{
        reg_write:  1'b0,
        write_addr: 5'd0,
        write_data: 32'd0,
        load_fault: 1'b0
    };

    // True for the five load types this core implements
    function automatic logic is_load_f3(input logic [2:0] f3);
        return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
               (f3 == F3_LBU) || (f3 == F3_LHU);
    endfunction

endpackage

// File: rtl/load_extend.sv
// Load lane select and sign/zero extension, plus alignment/encoding fault.
// Ports: funct3, byte_off, rdata in; data (extended word), fault out.
module load_extend
    import riscv_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  byte_off,
    input  logic [31:0] rdata,
    output logic [31:0] data,
    output logic        fault
);

    logic [31:0] lane;

    // Bring the addressed byte/half down to bit 0
    assign lane = rdata >> {byte_off, 3'b000};

    always_comb begin
        data  = 32'd0;
        fault = 1'b0;
        case (funct3)
            F3_LB: begin
                data = {{24{lane[7]}}, lane[7:0]};
            end
            F3_LBU: begin
                data = {24'd0, lane[7:0]};
            end
            F3_LH: begin
                data  = {{16{lane[15]}}, lane[15:0]};
                fault = byte_off[0];
            end
            F3_LHU: begin
                data  = {16'd0, lane[15:0]};
                fault = byte_off[0];
            end
            F3_LW: begin
                data  = rdata;
                fault = (byte_off != 2'b00);
            end
            default: begin
                fault = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: selects write-back data, gates writes, flags
// load faults and counts retired instructions.
// Ports: clk, rst (sync, active-high), Stall, Flush, In* MEM-stage fields in;
// RegWrite/WriteAddr/WriteData to the register file, LoadFault, RetireCount out.
module mem_wb_stage
    import riscv_pkg::*;
#(
    parameter int COUNT_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               Stall,
    input  logic               Flush,
    input  logic               InValid,
    input  logic               InRegWrite,
    input  logic [4:0]         InRd,
    input  logic [1:0]         InWbSel,
    input  logic [2:0]         InFunct3,
    input  logic [1:0]         InByteOff,
    input  logic [31:0]        InAluResult,
    input  logic [31:0]        InMemRdata,
    input  logic [31:0]        InPcPlus4,
    output logic               RegWrite,
    output logic [4:0]         WriteAddr,
    output logic [31:0]        WriteData,
    output logic               LoadFault,
    output logic [COUNT_W-1:0] RetireCount
);

    localparam logic [COUNT_W-1:0] CNT_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

    logic [31:0] load_data;
    logic        load_bad;
    logic        is_load;
    logic        fault;
    logic        do_write;
    logic        retire;
    logic [31:0] sel_data;
    wb_bundle_t  next_wb;
    wb_bundle_t  wb_q;
    logic [COUNT_W-1:0] count_q;

    load_extend u_load_extend (
        .funct3   (InFunct3),
        .byte_off (InByteOff),
        .rdata    (InMemRdata),
        .data     (load_data),
        .fault    (load_bad)
    );

    assign is_load  = (InWbSel == WB_LOAD);
    assign fault    = InValid & is_load & load_bad;
    assign do_write = InValid & InRegWrite & ~fault &
                      (InRd != REG_ZERO) & (InWbSel != WB_RSVD);
    // Non-writing instructions still retire; only faults do not
    assign retire   = InValid & ~fault;

    always_comb begin
        sel_data = 32'd0;
        case (InWbSel)
            WB_ALU:  sel_data = InAluResult;
            WB_LOAD: sel_data = load_data;
            WB_PC4:  sel_data = InPcPlus4;
            default: sel_data = 32'd0;
        endcase
    end

    // Address and data are forced to zero whenever no write happens so the
    // forwarding network never sees stale values.
    always_comb begin
        next_wb = WB_BUBBLE;
        if (InValid) begin
            next_wb.reg_write  = do_write;
            next_wb.write_addr = do_write ? InRd : 5'd0;
            next_wb.write_data = do_write ? sel_data : 32'd0;
            next_wb.load_fault = fault;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_q    <= WB_BUBBLE;
            count_q <= '0;
        end else if (Flush) begin
            wb_q    <= WB_BUBBLE;
        end else if (!Stall) begin
            wb_q    <= next_wb;
            if (retire) begin
                count_q <= count_q + CNT_ONE;
            end
        end
    end

    assign RegWrite    = wb_q.reg_write;
    assign WriteAddr   = wb_q.write_addr;
    assign WriteData   = wb_q.write_data;
    assign LoadFault   = wb_q.load_fault;
    assign RetireCount = count_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: a reference model pushes expected
// write-back state into a queue per edge; each test pops and compares.
module tb_mem_wb_stage;

    logic        clk;
    logic        rst;
    logic        Stall;
    logic        Flush;
    logic        InValid;
    logic        InRegWrite;
    logic [4:0]  InRd;
    logic [1:0]  InWbSel;
    logic [2:0]  InFunct3;
    logic [1:0]  InByteOff;
    logic [31:0] InAluResult;
    logic [31:0] InMemRdata;
    logic [31:0] InPcPlus4;

    logic        RegWrite;
    logic [4:0]  WriteAddr;
    logic [31:0] WriteData;
    logic        LoadFault;
    logic [31:0] RetireCount;

    logic        rw4;
    logic [4:0]  wa4;
    logic [31:0] wd4;
    logic        lf4;
    logic [3:0]  cnt4;

    typedef struct {
        bit          r;
        bit          st;
        bit          fl;
        bit          v;
        bit          rw;
        logic [4:0]  rd;
        logic [1:0]  sel;
        logic [2:0]  f3;
        logic [1:0]  off;
        logic [31:0] alu;
        logic [31:0] mem;
        logic [31:0] pc4;
    } stim_t;

    typedef struct {
        logic        rw;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        lf;
        logic [31:0] cnt;
    } exp_t;

    exp_t sb[$];
    exp_t m;
    int   tests;
    int   failed;

    mem_wb_stage u_dut (
        .clk         (clk),
        .rst         (rst),
        .Stall       (Stall),
        .Flush       (Flush),
        .InValid     (InValid),
        .InRegWrite  (InRegWrite),
        .InRd        (InRd),
        .InWbSel     (InWbSel),
        .InFunct3    (InFunct3),
        .InByteOff   (InByteOff),
        .InAluResult (InAluResult),
        .InMemRdata  (InMemRdata),
        .InPcPlus4   (InPcPlus4),
        .RegWrite    (RegWrite),
        .WriteAddr   (WriteAddr),
        .WriteData   (WriteData),
        .LoadFault   (LoadFault),
        .RetireCount (RetireCount)
    );

    mem_wb_stage #(.COUNT_W(4)) u_dut4 (
        .clk         (clk),
        .rst         (rst),
        .Stall       (Stall),
        .Flush       (Flush),
        .InValid     (InValid),
        .InRegWrite  (InRegWrite),
        .InRd        (InRd),
        .InWbSel     (InWbSel),
        .InFunct3    (InFunct3),
        .InByteOff   (InByteOff),
        .InAluResult (InAluResult),
        .InMemRdata  (InMemRdata),
        .InPcPlus4   (InPcPlus4),
        .RegWrite    (rw4),
        .WriteAddr   (wa4),
        .WriteData   (wd4),
        .LoadFault   (lf4),
        .RetireCount (cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic stim_t op(bit r, bit st, bit fl, bit v, bit rw,
                                 logic [4:0] rd, logic [1:0] sel,
                                 logic [2:0] f3, logic [1:0] off,
                                 logic [31:0] alu, logic [31:0] mem,
                                 logic [31:0] pc4);
        stim_t s;
        s.r = r; s.st = st; s.fl = fl; s.v = v; s.rw = rw;
        s.rd = rd; s.sel = sel; s.f3 = f3; s.off = off;
        s.alu = alu; s.mem = mem; s.pc4 = pc4;
        return s;
    endfunction

    function automatic stim_t alu_op(logic [4:0] rd, logic [31:0] val);
        return op(0, 0, 0, 1, 1, rd, 2'b00, 3'b000, 2'b00, val, 32'h0, 32'h0);
    endfunction

    function automatic stim_t ld_op(logic [2:0] f3, logic [1:0] off,
                                    logic [31:0] mem);
        return op(0, 0, 0, 1, 1, 5'd9, 2'b01, f3, off, 32'h0, mem, 32'h0);
    endfunction

    // Drive one edge worth of inputs, advance the model, push expectation,
    // then wait until just after the edge.
    task automatic apply(input stim_t s);
        logic        flt;
        logic [31:0] ld;
        logic [31:0] d;
        logic [7:0]  b;
        logic [15:0] h;
        logic        wr;
        rst = s.r; Stall = s.st; Flush = s.fl; InValid = s.v;
        InRegWrite = s.rw; InRd = s.rd; InWbSel = s.sel;
        InFunct3 = s.f3; InByteOff = s.off; InAluResult = s.alu;
        InMemRdata = s.mem; InPcPlus4 = s.pc4;
        if (s.r) begin
            m = '{rw: 0, wa: 0, wd: 0, lf: 0, cnt: 0};
        end else if (s.fl) begin
            m.rw = 0; m.wa = 0; m.wd = 0; m.lf = 0;
        end else if (s.st) begin
            m = m;
        end else if (!s.v) begin
            m.rw = 0; m.wa = 0; m.wd = 0; m.lf = 0;
        end else begin
            flt = 0;
            ld  = 32'h0;
            b   = s.mem[8*s.off +: 8];
            h   = (s.off >= 2) ? s.mem[31:16] : s.mem[15:0];
            if (s.sel == 2'b01) begin
                case (s.f3)
                    3'd0: ld = {{24{b[7]}}, b};
                    3'd4: ld = {24'h0, b};
                    3'd1: begin flt = s.off[0]; ld = {{16{h[15]}}, h}; end
                    3'd5: begin flt = s.off[0]; ld = {16'h0, h}; end
                    3'd2: begin flt = (s.off != 0); ld = s.mem; end
                    default: flt = 1;
                endcase
            end
            d = (s.sel == 2'b00) ? s.alu :
                (s.sel == 2'b01) ? ld :
                (s.sel == 2'b10) ? s.pc4 : 32'h0;
            wr = s.rw && !flt && (s.rd != 0) && (s.sel != 2'b11);
            m.rw = wr;
            m.wa = wr ? s.rd : 5'd0;
            m.wd = wr ? d : 32'h0;
            m.lf = flt;
            if (!flt) m.cnt = m.cnt + 1;
        end
        sb.push_back(m);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        apply(op(1, 1, 1, 1, 1, 5'd3, 2'b00, 3'd0, 2'd0, 32'h1234, 0, 0));
        e = sb.pop_front();
        tests++;
        if (RegWrite !== e.rw || WriteAddr !== e.wa || WriteData !== e.wd ||
            LoadFault !== e.lf || RetireCount !== e.cnt || cnt4 !== e.cnt[3:0]) begin
            failed++;
            $display("FAIL reset: got rw=%0b wa=%0d wd=%h lf=%0b cnt=%0d want %0b %0d %h %0b %0d",
                     RegWrite, WriteAddr, WriteData, LoadFault, RetireCount,
                     e.rw, e.wa, e.wd, e.lf, e.cnt);
        end
    endtask

    task automatic test_alu_write();
        exp_t e;
        apply(alu_op(5'd5, 32'hAAAAAAAA));
        e = sb.pop_front();
        tests++;
        if (RegWrite !== 1'b1 || WriteAddr !== 5'd5 || WriteData !== 32'hAAAAAAAA ||
            RetireCount !== 32'd1 || LoadFault !== e.lf || cnt4 !== e.cnt[3:0] ||
            RetireCount !== e.cnt) begin
            failed++;
            $display("FAIL alu_write: got rw=%0b wa=%0d wd=%h cnt=%0d want 1 5 aaaaaaaa 1",
                     RegWrite, WriteAddr, WriteData, RetireCount);
        end
    endtask

    task automatic test_loads();
        stim_t       s[6];
        logic [31:0] want[6];
        exp_t        e;
        s[0] = ld_op(3'd0, 2'd3, 32'h8899AABB); want[0] = 32'hFFFFFF88;
        s[1] = ld_op(3'd4, 2'd3, 32'h8899AABB); want[1] = 32'h00000088;
        s[2] = ld_op(3'd1, 2'd2, 32'h8899AABB); want[2] = 32'hFFFF8899;
        s[3] = ld_op(3'd5, 2'd0, 32'h8899AABB); want[3] = 32'h0000AABB;
        s[4] = ld_op(3'd2, 2'd0, 32'h8899AABB); want[4] = 32'h8899AABB;
        s[5] = ld_op(3'd0, 2'd1, 32'h12345678); want[5] = 32'h00000056;
        for (int i = 0; i < 6; i++) begin
            apply(s[i]);
            e = sb.pop_front();
            tests++;
            if (WriteData !== want[i] || RegWrite !== e.rw || WriteAddr !== e.wa ||
                WriteData !== e.wd || LoadFault !== e.lf || RetireCount !== e.cnt ||
                cnt4 !== e.cnt[3:0]) begin
                failed++;
                $display("FAIL load%0d: got rw=%0b wd=%h lf=%0b cnt=%0d want wd=%h cnt=%0d",
                         i, RegWrite, WriteData, LoadFault, RetireCount, want[i], e.cnt);
            end
        end
    endtask

    task automatic test_fault();
        stim_t s[5];
        exp_t  e;
        s[0] = ld_op(3'd2, 2'd2, 32'h8899AABB);
        s[1] = ld_op(3'd1, 2'd1, 32'h8899AABB);
        s[2] = alu_op(5'd7, 32'h77);
        s[3] = ld_op(3'd3, 2'd0, 32'h8899AABB);
        s[4] = ld_op(3'd5, 2'd3, 32'h8899AABB);
        for (int i = 0; i < 5; i++) begin
            apply(s[i]);
            e = sb.pop_front();
            tests++;
            if (RegWrite !== e.rw || WriteAddr !== e.wa || WriteData !== e.wd ||
                LoadFault !== e.lf || RetireCount !== e.cnt || cnt4 !== e.cnt[3:0]) begin
                failed++;
                $display("FAIL fault%0d: got rw=%0b wa=%0d wd=%h lf=%0b cnt=%0d want %0b %0d %h %0b %0d",
                         i, RegWrite, WriteAddr, WriteData, LoadFault, RetireCount,
                         e.rw, e.wa, e.wd, e.lf, e.cnt);
            end
        end
    endtask

    task automatic test_x0_rsvd_bubble();
        stim_t s[4];
        exp_t  e;
        s[0] = alu_op(5'd0, 32'hDEADBEEF);
        s[1] = op(0, 0, 0, 1, 1, 5'd4, 2'b11, 3'd0, 2'd0, 32'h5, 32'h6, 32'h7);
        s[2] = op(0, 0, 0, 0, 1, 5'd4, 2'b00, 3'd0, 2'd0, 32'h5, 32'h6, 32'h7);
        s[3] = op(0, 0, 0, 1, 0, 5'd4, 2'b10, 3'd0, 2'd0, 32'h5, 32'h6, 32'h7);
        for (int i = 0; i < 4; i++) begin
            apply(s[i]);
            e = sb.pop_front();
            tests++;
            if (RegWrite !== e.rw || WriteAddr !== e.wa || WriteData !== e.wd ||
                LoadFault !== e.lf || RetireCount !== e.cnt || cnt4 !== e.cnt[3:0]) begin
                failed++;
                $display("FAIL nowrite%0d: got rw=%0b wa=%0d wd=%h lf=%0b cnt=%0d want %0b %0d %h %0b %0d",
                         i, RegWrite, WriteAddr, WriteData, LoadFault, RetireCount,
                         e.rw, e.wa, e.wd, e.lf, e.cnt);
            end
        end
    endtask

    task automatic test_stall_flush();
        stim_t s[10];
        exp_t  e;
        s[0] = op(0, 0, 0, 1, 1, 5'd1, 2'b10, 3'd0, 2'd0, 32'h0, 32'h0, 32'h104);
        s[1] = op(0, 1, 0, 1, 1, 5'd2, 2'b00, 3'd0, 2'd0, 32'h99, 32'h0, 32'h0);
        s[2] = op(0, 1, 0, 1, 1, 5'd3, 2'b00, 3'd0, 2'd0, 32'h98, 32'h0, 32'h0);
        s[3] = op(0, 1, 0, 0, 0, 5'd0, 2'b00, 3'd0, 2'd0, 32'h0, 32'h0, 32'h0);
        s[4] = op(0, 1, 1, 1, 1, 5'd6, 2'b00, 3'd0, 2'd0, 32'h66, 32'h0, 32'h0);
        s[5] = ld_op(3'd2, 2'd1, 32'h1);
        s[6] = op(0, 1, 0, 1, 1, 5'd8, 2'b00, 3'd0, 2'd0, 32'h88, 32'h0, 32'h0);
        s[7] = op(0, 0, 0, 1, 1, 5'd1, 2'b10, 3'd0, 2'd0, 32'h0, 32'h0, 32'h200);
        s[8] = op(1, 1, 0, 1, 1, 5'd1, 2'b10, 3'd0, 2'd0, 32'h0, 32'h0, 32'h200);
        s[9] = alu_op(5'd5, 32'hAAAAAAAA);
        for (int i = 0; i < 10; i++) begin
            apply(s[i]);
            e = sb.pop_front();
            tests++;
            if (RegWrite !== e.rw || WriteAddr !== e.wa || WriteData !== e.wd ||
                LoadFault !== e.lf || RetireCount !== e.cnt || cnt4 !== e.cnt[3:0]) begin
                failed++;
                $display("FAIL stall%0d: got rw=%0b wa=%0d wd=%h lf=%0b cnt=%0d want %0b %0d %h %0b %0d",
                         i, RegWrite, WriteAddr, WriteData, LoadFault, RetireCount,
                         e.rw, e.wa, e.wd, e.lf, e.cnt);
            end
        end
    endtask

    task automatic test_wrap();
        exp_t e;
        apply(op(1, 0, 0, 0, 0, 5'd0, 2'b00, 3'd0, 2'd0, 0, 0, 0));
        void'(sb.pop_front());
        for (int i = 1; i <= 16; i++) begin
            apply(alu_op(5'(i), 32'(i)));
            e = sb.pop_front();
            tests++;
            if (RegWrite !== e.rw || WriteData !== e.wd || RetireCount !== e.cnt ||
                cnt4 !== e.cnt[3:0] || rw4 !== e.rw || wd4 !== e.wd) begin
                failed++;
                $display("FAIL wrap%0d: got cnt=%0d cnt4=%0d wd=%h want cnt=%0d cnt4=%0d wd=%h",
                         i, RetireCount, cnt4, WriteData, e.cnt, e.cnt[3:0], e.wd);
            end
        end
        tests++;
        if (cnt4 !== 4'd0 || RetireCount !== 32'd16) begin
            failed++;
            $display("FAIL wrap_end: got cnt4=%0d cnt=%0d want 0 16", cnt4, RetireCount);
        end
    endtask

    task automatic test_back_to_back();
        stim_t s;
        exp_t  e;
        for (int i = 0; i < 300; i++) begin
            s = op($urandom_range(0, 49) == 0, $urandom_range(0, 4) == 0,
                   $urandom_range(0, 9) == 0, $urandom_range(0, 5) != 0,
                   $urandom_range(0, 7) != 0, 5'($urandom),
                   2'($urandom), 3'($urandom), 2'($urandom),
                   $urandom, $urandom, $urandom);
            apply(s);
            e = sb.pop_front();
            tests++;
            if (RegWrite !== e.rw || WriteAddr !== e.wa || WriteData !== e.wd ||
                LoadFault !== e.lf || RetireCount !== e.cnt || cnt4 !== e.cnt[3:0] ||
                rw4 !== e.rw || wa4 !== e.wa || wd4 !== e.wd || lf4 !== e.lf) begin
                failed++;
                $display("FAIL b2b%0d: got rw=%0b wa=%0d wd=%h lf=%0b cnt=%0d want %0b %0d %h %0b %0d",
                         i, RegWrite, WriteAddr, WriteData, LoadFault, RetireCount,
                         e.rw, e.wa, e.wd, e.lf, e.cnt);
            end
        end
    endtask

    initial begin
        tests  = 0;
        failed = 0;
        m = '{rw: 0, wa: 0, wd: 0, lf: 0, cnt: 0};
        rst = 1; Stall = 0; Flush = 0; InValid = 0; InRegWrite = 0;
        InRd = 0; InWbSel = 0; InFunct3 = 0; InByteOff = 0;
        InAluResult = 0; InMemRdata = 0; InPcPlus4 = 0;
        test_reset();
        test_alu_write();
        test_loads();
        test_fault();
        test_x0_rsvd_bubble();
        test_stall_flush();
        test_wrap();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
